// File: rtl/index_pulse_meter_if.sv
// Bundle of the INDEX pin, the motor enable and the qualified index/period results.
// slave is the meter side and master is the consumer/driver side.
interface index_pulse_meter_if #(
  parameter int PERIOD_W = 25
);
  logic                index_in;
  logic                enable;
  logic                index_level;
  logic                index_pulse;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;
  logic                spinning;
  logic                timeout;

  modport master (
    output index_in, enable,
    input  index_level, index_pulse, period, period_valid, spinning, timeout
  );

  modport slave (
    input  index_in, enable,
    output index_level, index_pulse, period, period_valid, spinning, timeout
  );
endinterface

// File: rtl/index_pulse_meter.sv
// Turns the raw INDEX pin into a debounced level plus a one-cycle strobe per revolution.
// It also measures the revolution period and flags a stopped or absent disk after a silent timeout.
module index_pulse_meter #(
  parameter int SYNC_STAGES    = 2,
  parameter int MIN_PULSE      = 8,
  parameter int PERIOD_W       = 25,
  parameter int TIMEOUT_CYCLES = 16000000,
  parameter int ACTIVE_LOW     = 0
) (
  input logic                 clk,
  input logic                 rst,
  index_pulse_meter_if.slave  bus
);

  localparam int FW = (MIN_PULSE > 1) ? $clog2(MIN_PULSE) : 1;
  localparam logic PIN_IDLE = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    MEASURE    = 2'd1,
    STOPPED    = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FW-1:0]          filt_cnt_q, filt_cnt_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic [PERIOD_W-1:0]    cnt_q, cnt_d;
  logic [PERIOD_W-1:0]    period_q, period_d;
  logic                   period_valid_q, period_valid_d;
  logic                   spinning_q, spinning_d;
  logic                   timeout_q, timeout_d;
  state_t                 state_q, state_d;
  logic                   synced;
  logic                   cnt_expired;

  assign synced      = sync_q[SYNC_STAGES-1] ^ PIN_IDLE;
  assign cnt_expired = (cnt_q == PERIOD_W'(TIMEOUT_CYCLES));

  // Synchroniser and symmetric run-length filter on the synced pin.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], bus.index_in};
    filt_cnt_d = '0;
    level_d    = level_q;
    if (synced != level_q) begin
      if (filt_cnt_q == FW'(MIN_PULSE - 1)) begin
        level_d = ~level_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
    pulse_d = level_d & ~level_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!bus.enable) begin
      cnt_d = '0;
    end else if (pulse_q) begin
      cnt_d = PERIOD_W'(1);
    end else if (!(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // A pulse always beats an expiring counter; a dropping enable beats both.
  always_comb begin
    state_d        = state_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    spinning_d     = spinning_q;
    timeout_d      = timeout_q;
    if (!bus.enable) begin
      state_d    = WAIT_FIRST;
      spinning_d = 1'b0;
      timeout_d  = 1'b0;
    end else begin
      case (state_q)
        WAIT_FIRST: begin
          if (pulse_q) begin
            state_d = MEASURE;
          end else if (cnt_expired) begin
            state_d    = STOPPED;
            timeout_d  = 1'b1;
            spinning_d = 1'b0;
          end
        end
        MEASURE: begin
          if (pulse_q) begin
            period_d       = cnt_q;
            period_valid_d = 1'b1;
            spinning_d     = 1'b1;
          end else if (cnt_expired) begin
            state_d    = STOPPED;
            timeout_d  = 1'b1;
            spinning_d = 1'b0;
          end
        end
        STOPPED: begin
          spinning_d = 1'b0;
          if (pulse_q) begin
            state_d   = MEASURE;
            timeout_d = 1'b0;
          end
        end
        default: begin
          state_d = WAIT_FIRST;
        end
      endcase
    end
  end

  // The synchroniser resets to the idle pin level so an active-low pin does not look asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q         <= {SYNC_STAGES{PIN_IDLE}};
      filt_cnt_q     <= '0;
      level_q        <= 1'b0;
      pulse_q        <= 1'b0;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      spinning_q     <= 1'b0;
      timeout_q      <= 1'b0;
      state_q        <= WAIT_FIRST;
    end else begin
      sync_q         <= sync_d;
      filt_cnt_q     <= filt_cnt_d;
      level_q        <= level_d;
      pulse_q        <= pulse_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      spinning_q     <= spinning_d;
      timeout_q      <= timeout_d;
      state_q        <= state_d;
    end
  end

  assign bus.index_level  = level_q;
  assign bus.index_pulse  = pulse_q;
  assign bus.period       = period_q;
  assign bus.period_valid = period_valid_q;
  assign bus.spinning     = spinning_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_index_pulse_meter.sv
// Randomised bench for index_pulse_meter; expectations come from a raw-pin run-length model
// and from the revolution timing the stimulus itself schedules.
module tb_index_pulse_meter;
  localparam int SYNC_STAGES = 2;
  localparam int MIN_PULSE   = 8;
  localparam int PERIOD_W    = 25;
  localparam int T           = 5000;
  localparam int LAT         = SYNC_STAGES + MIN_PULSE;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  index_pulse_meter_if #(.PERIOD_W(PERIOD_W)) bus ();

  index_pulse_meter #(
    .SYNC_STAGES(SYNC_STAGES), .MIN_PULSE(MIN_PULSE), .PERIOD_W(PERIOD_W),
    .TIMEOUT_CYCLES(T), .ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int last_rise;
  logic [PERIOD_W-1:0] exp_period;

  int                  pulse_cyc[$];
  logic [PERIOD_W-1:0] pv_val[$];
  int                  pv_cyc[$];
  int                  exp_cyc[$];
  int                  lvl_hi = 0;
  int                  tmo_hi = 0;
  logic                in_tr [0:131071];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    in_tr[cyc] = bus.index_in;
    if (bus.index_pulse === 1'b1) pulse_cyc.push_back(cyc);
    if (bus.period_valid === 1'b1) begin
      pv_val.push_back(bus.period);
      pv_cyc.push_back(cyc);
    end
    if (bus.index_level === 1'b1) lvl_hi++;
    if (bus.timeout === 1'b1) tmo_hi++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    bus.index_in = v;
    repeat (n) tick();
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic clear_mon();
    pulse_cyc.delete();
    pv_val.delete();
    pv_cyc.delete();
    lvl_hi = 0;
    tmo_hi = 0;
  endtask

  // The filtered level flips once the raw pin has disagreed with it for MIN_PULSE
  // consecutive cycles; the flip is seen SYNC_STAGES+1 cycles after the last such cycle.
  function automatic void build_model(input int s, input int e);
    logic lvl;
    int   run;
    lvl = 1'b0;
    run = 0;
    exp_cyc.delete();
    for (int c = s; c <= e; c++) begin
      if (in_tr[c] != lvl) run++;
      else run = 0;
      if (run == MIN_PULSE) begin
        lvl = ~lvl;
        run = 0;
        if (lvl) exp_cyc.push_back(c + SYNC_STAGES + 1);
      end
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.index_in = 1'b0;
    bus.enable = 1'b0;
    repeat (3) tick();
    total++;
    if ({bus.index_level, bus.index_pulse, bus.period_valid, bus.spinning, bus.timeout} !== 5'b0)
      $display("FAIL reset_flags got=%b want=00000",
               {bus.index_level, bus.index_pulse, bus.period_valid, bus.spinning, bus.timeout});
    else passed++;
    total++;
    if (bus.period !== '0) $display("FAIL reset_period got=%0d want=0", bus.period);
    else passed++;
    rst = 1'b0;
    hold(1'b0, 12);
  endtask

  task automatic test_glitch();
    int s;
    int bad;
    clear_mon();
    s = cyc;
    for (int i = 0; i < 6; i++) begin
      hold(1'b1, (i == 0) ? 5 : int'($urandom_range(1, MIN_PULSE - 1)));
      hold(1'b0, $urandom_range(12, 20));
    end
    build_model(s, cyc - 1);
    total++;
    if (pulse_cyc.size() !== 0) $display("FAIL glitch_pulses got=%0d want=0", pulse_cyc.size());
    else passed++;
    total++;
    if (lvl_hi !== 0) $display("FAIL glitch_level_high_cycles got=%0d want=0", lvl_hi);
    else passed++;
    bad = (pulse_cyc.size() != exp_cyc.size()) ? 1 : 0;
    total++;
    if (bad != 0) $display("FAIL glitch_model got=%0d pulses want=%0d", pulse_cyc.size(), exp_cyc.size());
    else passed++;
  endtask

  task automatic test_burst();
    int s;
    int rise;
    int bad;
    clear_mon();
    s = cyc;
    for (int i = 0; i < 6; i++) begin
      hold(1'b1, (i == 0) ? 5 : int'($urandom_range(1, MIN_PULSE - 1)));
      hold(1'b0, (i == 0) ? 5 : int'($urandom_range(1, MIN_PULSE - 1)));
    end
    rise = cyc;
    hold(1'b1, 20);
    hold(1'b0, 20);
    build_model(s, cyc - 1);
    total++;
    if (pulse_cyc.size() !== 1) $display("FAIL burst_pulse_count got=%0d want=1", pulse_cyc.size());
    else passed++;
    total++;
    if (pulse_cyc.size() < 1 || pulse_cyc[0] !== rise + LAT)
      $display("FAIL burst_pulse_cycle got=%0d want=%0d", (pulse_cyc.size() > 0) ? pulse_cyc[0] : -1, rise + LAT);
    else passed++;
    bad = (pulse_cyc.size() != exp_cyc.size()) ? 1 : 0;
    for (int i = 0; i < pulse_cyc.size() && bad == 0; i++) if (pulse_cyc[i] != exp_cyc[i]) bad = 1;
    total++;
    if (bad != 0) $display("FAIL burst_model got=%0d pulses want=%0d", pulse_cyc.size(), exp_cyc.size());
    else passed++;
  endtask

  task automatic test_period();
    int gaps[4];
    int rises[5];
    int s;
    int bad;
    gaps[0] = 1000;
    gaps[1] = 1000;
    gaps[2] = $urandom_range(300, 2000);
    gaps[3] = $urandom_range(300, 2000);
    bus.enable = 1'b1;
    hold(1'b0, 5);
    clear_mon();
    s = cyc;
    for (int i = 0; i < 5; i++) begin
      rises[i] = cyc;
      hold(1'b1, 12);
      if (i == 0) begin
        total++;
        if (bus.spinning !== 1'b0) $display("FAIL period_first_pulse_spinning got=%b want=0", bus.spinning);
        else passed++;
      end
      hold(1'b0, (i < 4) ? gaps[i] - 12 : 15);
    end
    build_model(s, cyc - 1);
    total++;
    if (pv_val.size() !== 4) $display("FAIL period_valid_count got=%0d want=4", pv_val.size());
    else passed++;
    for (int i = 0; i < 4 && i < pv_val.size(); i++) begin
      total++;
      if (pv_val[i] !== PERIOD_W'(gaps[i]))
        $display("FAIL period_value[%0d] got=%0d want=%0d", i, pv_val[i], gaps[i]);
      else passed++;
      total++;
      if (pv_cyc[i] !== rises[i+1] + LAT + 1)
        $display("FAIL period_valid_cycle[%0d] got=%0d want=%0d", i, pv_cyc[i], rises[i+1] + LAT + 1);
      else passed++;
    end
    total++;
    if (bus.spinning !== 1'b1) $display("FAIL period_spinning got=%b want=1", bus.spinning);
    else passed++;
    bad = (pulse_cyc.size() != exp_cyc.size()) ? 1 : 0;
    for (int i = 0; i < pulse_cyc.size() && bad == 0; i++) if (pulse_cyc[i] != exp_cyc[i]) bad = 1;
    total++;
    if (bad != 0) $display("FAIL period_pulse_model got=%0d pulses want=%0d", pulse_cyc.size(), exp_cyc.size());
    else passed++;
    last_rise = rises[4];
    exp_period = PERIOD_W'(gaps[3]);
  endtask

  task automatic test_timeout();
    int   t;
    int   g;
    int   r2;
    logic sp_before;
    t = -1;
    sp_before = 1'b0;
    for (int i = 0; i < T + 200; i++) begin
      tick();
      if (bus.timeout === 1'b1) begin
        t = cyc;
        break;
      end
      sp_before = bus.spinning;
    end
    total++;
    if (t !== last_rise + LAT + T + 1)
      $display("FAIL timeout_cycle got=%0d want=%0d", t, last_rise + LAT + T + 1);
    else passed++;
    total++;
    if (sp_before !== 1'b1 || bus.spinning !== 1'b0)
      $display("FAIL timeout_spinning got=%b->%b want=1->0", sp_before, bus.spinning);
    else passed++;
    g = $urandom_range(300, 1000);
    clear_mon();
    hold(1'b1, 12);
    total++;
    if (bus.timeout !== 1'b0) $display("FAIL timeout_clear got=%b want=0", bus.timeout);
    else passed++;
    total++;
    if (pv_val.size() !== 0) $display("FAIL timeout_restart_no_valid got=%0d want=0", pv_val.size());
    else passed++;
    hold(1'b0, g - 12);
    r2 = cyc;
    hold(1'b1, 12);
    hold(1'b0, 20);
    total++;
    if (pv_val.size() !== 1 || pv_val[0] !== PERIOD_W'(g))
      $display("FAIL timeout_remeasure got=%0d values (first %0d) want=1 value %0d",
               pv_val.size(), (pv_val.size() > 0) ? pv_val[0] : '0, g);
    else passed++;
    last_rise = r2;
    exp_period = PERIOD_W'(g);
  endtask

  task automatic test_back_to_back_timeout_edge();
    int r;
    wait_until(last_rise + T);
    clear_mon();
    r = cyc;
    hold(1'b1, 12);
    hold(1'b0, 20);
    total++;
    if (pv_val.size() !== 1 || pv_val[0] !== PERIOD_W'(T))
      $display("FAIL edge_pulse_wins got=%0d values (first %0d) want=1 value %0d",
               pv_val.size(), (pv_val.size() > 0) ? pv_val[0] : '0, T);
    else passed++;
    total++;
    if (tmo_hi !== 0) $display("FAIL edge_no_timeout got=%0d cycles want=0", tmo_hi);
    else passed++;
    last_rise = r;
    exp_period = PERIOD_W'(T);
  endtask

  task automatic test_enable_drop();
    int r;
    wait_until(last_rise + int'($urandom_range(300, 1000)));
    clear_mon();
    r = cyc;
    hold(1'b1, LAT);
    bus.enable = 1'b0;
    hold(1'b1, 2);
    hold(1'b0, 20);
    total++;
    if (pv_val.size() !== 0) $display("FAIL endrop_no_valid got=%0d want=0", pv_val.size());
    else passed++;
    total++;
    if (bus.period !== exp_period) $display("FAIL endrop_period_held got=%0d want=%0d", bus.period, exp_period);
    else passed++;
    total++;
    if (bus.spinning !== 1'b0 || bus.timeout !== 1'b0)
      $display("FAIL endrop_flags got=%b%b want=00", bus.spinning, bus.timeout);
    else passed++;
    total++;
    if (pulse_cyc.size() !== 1 || pulse_cyc[0] !== r + LAT)
      $display("FAIL endrop_pulse got=%0d pulses want=1 at %0d", pulse_cyc.size(), r + LAT);
    else passed++;
    bus.enable = 1'b1;
    hold(1'b0, 10);
  endtask

  task automatic test_reset_mid();
    int g;
    g = $urandom_range(300, 1000);
    hold(1'b1, 12);
    hold(1'b0, g - 12);
    hold(1'b1, 12);
    hold(1'b0, 20);
    total++;
    if (bus.spinning !== 1'b1 || bus.period !== PERIOD_W'(g))
      $display("FAIL rstmid_setup got=%b/%0d want=1/%0d", bus.spinning, bus.period, g);
    else passed++;
    clear_mon();
    hold(1'b1, 5);
    rst = 1'b1;
    tick();
    total++;
    if ({bus.index_level, bus.index_pulse, bus.period_valid, bus.spinning, bus.timeout} !== 5'b0
        || bus.period !== '0)
      $display("FAIL rstmid_outputs got=%b/%0d want=00000/0",
               {bus.index_level, bus.index_pulse, bus.period_valid, bus.spinning, bus.timeout}, bus.period);
    else passed++;
    repeat (8) tick();
    rst = 1'b0;
    repeat (6) tick();
    hold(1'b0, 30);
    total++;
    if (pulse_cyc.size() !== 0 || lvl_hi !== 0)
      $display("FAIL rstmid_no_pulse got=%0d pulses %0d level cycles want=0 0", pulse_cyc.size(), lvl_hi);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_burst();
    test_period();
    test_timeout();
    test_back_to_back_timeout_edge();
    test_enable_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
